// File: rtl/serial_parity_transmitter.sv
// Even-parity serial transmitter: accepts a word on ready/start, shifts it out LSB first, then appends one parity bit.
// Optional build macro SERIAL_TX_ODD_PARITY_EN switches the appended bit to odd parity.
module serial_parity_transmitter #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready,
  output logic                  serial_output,
  output logic                  bit_valid,
  output logic                  parity_bit
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shiftReg;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  parityAcc;
  logic                  loadParity;
  logic [CW-1:0]         bitCount;

  assign shifted = shiftReg >> 1;

`ifdef SERIAL_TX_ODD_PARITY_EN
  assign loadParity = ~(^data_in);
`else
  assign loadParity = ^data_in;
`endif

  // Outputs are registered with the value of the state being entered, so the first data bit is on the line right after the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ready         <= 1'b1;
      serial_output <= 1'b0;
      bit_valid     <= 1'b0;
      parity_bit    <= 1'b0;
      shiftReg      <= '0;
      parityAcc     <= 1'b0;
      bitCount      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state         <= DATA;
            ready         <= 1'b0;
            shiftReg      <= data_in;
            parityAcc     <= loadParity;
            bitCount      <= '0;
            serial_output <= data_in[0];
            bit_valid     <= 1'b1;
            parity_bit    <= 1'b0;
          end
        end
        DATA: begin
          shiftReg <= shifted;
          bitCount <= bitCount + 1'b1;
          if (bitCount == LAST_BIT) begin
            state         <= PARITY;
            serial_output <= parityAcc;
            parity_bit    <= 1'b1;
          end else begin
            serial_output <= shifted[0];
          end
        end
        PARITY: begin
          state         <= IDLE;
          ready         <= 1'b1;
          serial_output <= 1'b0;
          bit_valid     <= 1'b0;
          parity_bit    <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          ready         <= 1'b1;
          serial_output <= 1'b0;
          bit_valid     <= 1'b0;
          parity_bit    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_parity_transmitter.md
Name: serial_parity_transmitter

Overview:
- Transmit side of the serial even-parity link; the checking end is our serial parity detector.
- Accepts a parallel word through a ready/start handshake and shifts it out LSB first, one bit per clock.
- Appends one parity bit so the total number of 1s in the frame (data plus parity) is even.
- Sits between a parallel data source and the single-bit serial line feeding the detector.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame; legal range 1 to 32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to send; sampled only while ready=1.
- data_in  input  DATA_WIDTH  word to send; captured on the accept edge.
- ready  output  1  block is IDLE and can accept a word.
- serial_output  output  1  serial line: data bits, then the parity bit.
- bit_valid  output  1  serial_output carries a frame bit this cycle.
- parity_bit  output  1  high only while serial_output carries the parity bit.

Behaviour:
- All outputs are registered; no combinational path from input to output.
- Reset values, applied at the clk edge with reset=1: state=IDLE, ready=1, serial_output=0, bit_valid=0, parity_bit=0. The shift register, parity accumulator and bit counter are cleared.
- FSM states: IDLE, DATA, PARITY.
- IDLE:
  - ready=1, bit_valid=0, serial_output=0.
  - On an edge with start=1, the word is accepted: data_in goes into the shift register, the parity accumulator is set to the XOR-reduction of data_in, and the bit counter is set to 0.
  - On that same edge the state becomes DATA and ready drops to 0.
- DATA:
  - serial_output = current shift-register bit 0; bit_valid=1, parity_bit=0.
  - Each edge shifts right by one and increments the counter.
  - After DATA_WIDTH bits have been presented, the next state is PARITY.
  - Bit i of the captured word appears i+1 cycles after the accept edge.
- PARITY:
  - Lasts exactly one cycle: serial_output = parity accumulator, bit_valid=1, parity_bit=1.
  - The next state is IDLE, and ready returns to 1 on that same edge.
- Frame length is DATA_WIDTH+1 valid cycles. Minimum spacing between accept edges is DATA_WIDTH+2 cycles, because ready is deasserted for the whole frame.
- start while ready=0 is ignored: it is not queued and does not change the frame in flight.
- data_in changes after the accept edge have no effect on the frame in flight.
- start held high continuously produces back-to-back frames with exactly one IDLE cycle between them.
- reset mid-frame, in DATA or PARITY: on that edge the block goes to IDLE with reset values. No parity bit is emitted for the aborted frame.
- reset and start high on the same edge: reset wins and the word is not accepted.
- Counter width is clog2(DATA_WIDTH)+1 bits. It never wraps within a frame and is cleared on accept.

Optional Feature:
- Macro: SERIAL_TX_ODD_PARITY_EN.
- Defined: the accumulator loads the inverted XOR-reduction, so the frame total of 1s is odd.
- Undefined (default): even parity as described above.
- Frame timing and handshake are identical in both builds.

Test Plan:
- Reset: hold reset 2 cycles, then release with start=0 -> ready=1, bit_valid=0, serial_output=0, parity_bit=0 for 5 cycles.
- Even word: DATA_WIDTH=8, start=1 with data_in=8'hB2 for one cycle -> serial_output over the next 9 cycles is 0,1,0,0,1,1,0,1 then parity 0. bit_valid=1 for those 9 cycles; parity_bit=1 only on the 9th; ready=1 on the cycle after.
- Odd word: data_in=8'h07 -> bits 1,1,1,0,0,0,0,0 then parity 1. With SERIAL_TX_ODD_PARITY_EN defined the parity is 0, and 8'hB2 gives parity 1.
- Ignored start and back-to-back: pulse start with data_in=8'hFF during the DATA state of an 8'h01 frame -> the frame completes as 1,0,0,0,0,0,0,0,1 and 8'hFF is never sent. Then hold start=1 with data_in=8'h03 -> consecutive frames separated by exactly one IDLE cycle, each ending in parity 0.
- Reset mid-frame: assert reset on the 4th data bit of 8'hA5 -> the next cycle has bit_valid=0 and ready=1 with no parity bit. A following start with 8'h01 transmits correctly.
- Loopback with detector: connect serial_output to the detector input and gate the detector with bit_valid. Send random words (e.g. 200) -> after each even-parity frame the detector saida=0; with SERIAL_TX_ODD_PARITY_EN defined, saida=1.
